combined: RTL and testbench



---
 rtl/combined.sv | 61 ++++++
 tb/tb_combined.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/combined.sv
// Four fixed-coefficient 5-tap FIR filters (low-pass, high-pass, band-pass,
// moving-average) sharing one signed 16-bit delay line; outputs registered.
module combined (
    input  logic signed [15:0] in,
    input  logic               clk,
    output logic signed [15:0] LP_out,
    output logic signed [15:0] HP_out,
    output logic signed [15:0] BP_out,
    output logic signed [15:0] MA_out,
    input  logic               rst
);

    logic signed [15:0] r_x [0:4];

    logic signed [23:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic signed [23:0] w_lp_sum, w_hp_sum, w_bp_sum, w_ma_sum;

    // Clamp a shifted accumulator into the 16-bit signed output range.
    function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
        if (v > 24'sd32767)
            return 16'sh7fff;
        else if (v < -24'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Taps seen by this edge's result: the new sample plus the old x0..x3.
    always_comb begin
        w_t0 = {{8{in[15]}}, in};
        w_t1 = {{8{r_x[0][15]}}, r_x[0]};
        w_t2 = {{8{r_x[1][15]}}, r_x[1]};
        w_t3 = {{8{r_x[2][15]}}, r_x[2]};
        w_t4 = {{8{r_x[3][15]}}, r_x[3]};

        w_lp_sum = w_t0 + (w_t1 <<< 2) + (w_t2 * 24'sd6) + (w_t3 <<< 2) + w_t4;
        w_hp_sum = (w_t2 * 24'sd10) - w_t0 - (w_t1 <<< 2) - (w_t3 <<< 2) - w_t4;
        w_bp_sum = (w_t2 <<< 1) - w_t0 - w_t4;
        w_ma_sum = w_t0 + w_t1 + w_t2 + w_t3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 5; k++)
                r_x[k] <= '0;
            LP_out <= '0;
            HP_out <= '0;
            BP_out <= '0;
            MA_out <= '0;
        end else begin
            r_x[0] <= in;
            for (int unsigned k = 1; k < 5; k++)
                r_x[k] <= r_x[k-1];
            LP_out <= sat16(w_lp_sum >>> 4);
            HP_out <= sat16(w_hp_sum >>> 4);
            BP_out <= sat16(w_bp_sum >>> 2);
            MA_out <= sat16(w_ma_sum >>> 2);
        end
    end

endmodule

// File: tb/tb_combined.sv
// Self-checking bench for the combined FIR bank: directed impulse/tone/extreme
// sequences plus random samples, compared against a history-based reference.
module tb_combined;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in  = '0;
    logic signed [15:0] LP_out, HP_out, BP_out, MA_out;

    int total = 0;
    int bad   = 0;

    int    hist [5];
    int    coef [4][5] = '{'{1, 4, 6, 4, 1}, '{-1, -4, 10, -4, -1},
                           '{-1, 0, 2, 0, -1}, '{1, 1, 1, 1, 0}};
    int    divs [4]    = '{16, 16, 4, 4};
    string nm   [4]    = '{"LP", "HP", "BP", "MA"};

    combined dut (
        .in    (in),
        .clk   (clk),
        .LP_out(LP_out),
        .HP_out(HP_out),
        .BP_out(BP_out),
        .MA_out(MA_out),
        .rst   (rst)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic int model_out(input int f);
        int acc;
        int q;
        acc = 0;
        for (int k = 0; k < 5; k++)
            acc += coef[f][k] * hist[k];
        q = fdiv(acc, divs[f]);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One edge: drive, update the reference history, then check all outputs.
    task automatic step(input int s, input bit r);
        int o [4];
        @(negedge clk);
        in  = 16'(s);
        rst = r;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 5; k++) hist[k] = 0;
        end else begin
            for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
        end
        #1;
        o = '{int'(LP_out), int'(HP_out), int'(BP_out), int'(MA_out)};
        for (int f = 0; f < 4; f++)
            chk({"model_", nm[f]}, o[f], model_out(f));
    endtask

    initial begin
        int imp_lp [5] = '{1, 4, 6, 4, 1};
        int imp_hp [5] = '{-1, -4, 10, -4, -1};
        int imp_bp [5] = '{-4, 0, 8, 0, -4};
        int imp_ma [5] = '{4, 4, 4, 4, 0};
        int qr     [4] = '{50, 0, -50, 0};
        int qr_lp  [4] = '{-13, 0, 12, 0};
        int qr_hp  [4] = '{-38, 0, 37, 0};
        int qr_bp  [4] = '{-50, 0, 50, 0};
        int s;

        for (int k = 0; k < 5; k++) hist[k] = 0;

        // Reset with a non-zero input present.
        step(1234, 1'b1);
        step(1234, 1'b1);
        chk("rst_LP", LP_out, 0);
        chk("rst_HP", HP_out, 0);
        for (int k = 0; k < 5; k++)
            chk("rst_x", dut.r_x[k], 0);

        // Impulse response.
        for (int e = 0; e < 7; e++) begin
            step((e == 0) ? 16 : 0, 1'b0);
            chk("imp_LP", LP_out, (e < 5) ? imp_lp[e] : 0);
            chk("imp_HP", HP_out, (e < 5) ? imp_hp[e] : 0);
            chk("imp_BP", BP_out, (e < 5) ? imp_bp[e] : 0);
            chk("imp_MA", MA_out, (e < 5) ? imp_ma[e] : 0);
        end

        // Nyquist tone.
        for (int e = 0; e < 10; e++) begin
            s = (e % 2 == 0) ? 50 : -50;
            step(s, 1'b0);
            if (e >= 4) begin
                chk("nyq_LP", LP_out, 0);
                chk("nyq_BP", BP_out, 0);
                chk("nyq_MA", MA_out, 0);
                chk("nyq_HP", HP_out, s);
            end
        end

        // Quarter-rate tone.
        for (int e = 0; e < 12; e++) begin
            step(qr[e % 4], 1'b0);
            if (e >= 5) begin
                chk("qr_LP", LP_out, qr_lp[e % 4]);
                chk("qr_HP", HP_out, qr_hp[e % 4]);
                chk("qr_BP", BP_out, qr_bp[e % 4]);
                chk("qr_MA", MA_out, 0);
            end
        end

        // DC step from a cleared history.
        step(0, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            step(1000, 1'b0);
            if (e >= 4) chk("dc_MA", MA_out, 1000);
            if (e >= 5) begin
                chk("dc_LP", LP_out, 1000);
                chk("dc_HP", HP_out, 0);
                chk("dc_BP", BP_out, 0);
            end
        end

        // Full-scale alternation: HP must reach both rails without wrapping.
        for (int e = 0; e < 10; e++) begin
            s = (e % 2 == 0) ? 32767 : -32768;
            step(s, 1'b0);
            if (e >= 4) chk("ext_HP", HP_out, (s > 0) ? 32767 : -32768);
        end

        // Single-edge reset mid-stream, then impulse again.
        step(-32768, 1'b1);
        for (int e = 0; e < 6; e++) begin
            step((e == 0) ? 16 : 0, 1'b0);
            chk("rimp_LP", LP_out, (e < 5) ? imp_lp[e] : 0);
            chk("rimp_HP", HP_out, (e < 5) ? imp_hp[e] : 0);
            chk("rimp_BP", BP_out, (e < 5) ? imp_bp[e] : 0);
            chk("rimp_MA", MA_out, (e < 5) ? imp_ma[e] : 0);
        end

        // Random full-range samples with occasional resets.
        for (int e = 0; e < 300; e++)
            step(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 39) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
